instruction_decoder_stream: RTL and testbench



---
 rtl/instr_dec_pkg.sv | 24 ++
 rtl/instr_onehot_dec.sv | 25 ++
 rtl/instruction_decoder_stream.sv | 141 ++++++++++++++
 tb/tb_instruction_decoder_stream.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/instr_dec_pkg.sv
// Shared types and constants for the streaming instruction decoder.
package instr_dec_pkg;

    // Decoder FSM: expecting an opcode word, or the immediate of a saved opcode
    typedef enum logic {
        S_OP  = 1'b0,
        S_IMM = 1'b1
    } state_e;

    // Widest opcode the legality helper supports (256-entry mask)
    localparam int MAX_OP_W = 8;
    localparam int MAX_MASK_W = 2**MAX_OP_W;

    // Default masks for the 4-bit opcode space: 9 and 14 illegal, 4 and 5 take an immediate
    localparam logic [15:0] DEF_LEGAL_MASK = 16'hBDFF;
    localparam logic [15:0] DEF_IMM_MASK   = 16'h0030;

    // Look up an opcode in a legality mask (callers zero-extend to the max width)
    function automatic logic is_legal(input logic [MAX_OP_W-1:0]   opcode,
                                      input logic [MAX_MASK_W-1:0] mask);
        return mask[opcode];
    endfunction

endpackage

// File: rtl/instr_onehot_dec.sv
// Combinational opcode to one-hot decode with legality check; illegal opcodes decode to zero.
module instr_onehot_dec
    import instr_dec_pkg::*;
#(
    parameter int                  OP_W       = 4,
    parameter logic [2**OP_W-1:0]  LEGAL_MASK = DEF_LEGAL_MASK
) (
    input  logic [OP_W-1:0]       opcode,
    output logic [2**OP_W-1:0]    onehot,
    output logic                  legal
);

    localparam int NOP = 2**OP_W;
    localparam logic [MAX_MASK_W-1:0] MASK_EXT = MAX_MASK_W'(LEGAL_MASK);

    logic [MAX_OP_W-1:0] op_ext;

    // Widen the opcode to the helper's fixed argument width, then decode
    always_comb begin
        op_ext = MAX_OP_W'(opcode);
        legal  = is_legal(op_ext, MASK_EXT);
        onehot = legal ? ({{(NOP-1){1'b0}}, 1'b1} << opcode) : '0;
    end

endmodule

// File: rtl/instruction_decoder_stream.sv
// Registered opcode decoder on a valid/ready stream; immediate-bearing opcodes
// absorb the following word, illegal opcodes are flagged and counted.
module instruction_decoder_stream
    import instr_dec_pkg::*;
#(
    parameter int                  OP_W       = 4,
    parameter int                  DATA_W     = 8,
    parameter logic [2**OP_W-1:0]  LEGAL_MASK = DEF_LEGAL_MASK,
    parameter logic [2**OP_W-1:0]  IMM_MASK   = DEF_IMM_MASK,
    parameter int                  CNT_W      = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_W-1:0]     in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [2**OP_W-1:0]    out_onehot,
    output logic [OP_W-1:0]       out_opcode,
    output logic [DATA_W-1:0]     out_imm,
    output logic                  out_has_imm,
    output logic                  out_illegal,
    output logic [CNT_W-1:0]      illegal_count
);

    localparam int NOP = 2**OP_W;

    state_e              state_q, state_d;
    logic [OP_W-1:0]     saved_op_q, saved_op_d;
    logic                valid_q, valid_d;
    logic [NOP-1:0]      onehot_q, onehot_d;
    logic [OP_W-1:0]     opcode_q, opcode_d;
    logic [DATA_W-1:0]   imm_q, imm_d;
    logic                has_imm_q, has_imm_d;
    logic                illegal_q, illegal_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic                in_xfer, out_xfer;
    logic [OP_W-1:0]     in_op, dec_op;
    logic [NOP-1:0]      dec_onehot;
    logic                dec_legal;

    assign in_ready = rst_n && !flush && (!valid_q || out_ready);
    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = valid_q && out_ready;
    assign in_op    = in_data[DATA_W-1 -: OP_W];
    // In S_IMM the saved opcode is what gets decoded; the input word is the immediate
    assign dec_op   = (state_q == S_IMM) ? saved_op_q : in_op;

    instr_onehot_dec #(
        .OP_W       (OP_W),
        .LEGAL_MASK (LEGAL_MASK)
    ) u_dec (
        .opcode (dec_op),
        .onehot (dec_onehot),
        .legal  (dec_legal)
    );

    // Next-state: handshake, FSM, output register load and saturating illegal counter
    always_comb begin
        state_d    = state_q;
        saved_op_d = saved_op_q;
        valid_d    = valid_q;
        onehot_d   = onehot_q;
        opcode_d   = opcode_q;
        imm_d      = imm_q;
        has_imm_d  = has_imm_q;
        illegal_d  = illegal_q;
        cnt_d      = cnt_q;

        if (out_xfer) valid_d = 1'b0;

        if (in_xfer) begin
            if (state_q == S_OP) begin
                if (dec_legal && IMM_MASK[in_op]) begin
                    // Hold the opcode until its immediate arrives; output register untouched
                    saved_op_d = in_op;
                    state_d    = S_IMM;
                end else begin
                    valid_d   = 1'b1;
                    onehot_d  = dec_onehot;
                    opcode_d  = in_op;
                    imm_d     = '0;
                    has_imm_d = 1'b0;
                    illegal_d = !dec_legal;
                    if (!dec_legal && cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + 1'b1;
                end
            end else begin
                valid_d   = 1'b1;
                onehot_d  = dec_onehot;
                opcode_d  = saved_op_q;
                imm_d     = in_data;
                has_imm_d = 1'b1;
                illegal_d = 1'b0;
                state_d   = S_OP;
            end
        end

        // flush beats any concurrent output transfer; input is already blocked
        if (flush) begin
            valid_d = 1'b0;
            state_d = S_OP;
        end
    end

    // State and output registers with asynchronous reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_OP;
            saved_op_q <= '0;
            valid_q    <= 1'b0;
            onehot_q   <= '0;
            opcode_q   <= '0;
            imm_q      <= '0;
            has_imm_q  <= 1'b0;
            illegal_q  <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            saved_op_q <= saved_op_d;
            valid_q    <= valid_d;
            onehot_q   <= onehot_d;
            opcode_q   <= opcode_d;
            imm_q      <= imm_d;
            has_imm_q  <= has_imm_d;
            illegal_q  <= illegal_d;
            cnt_q      <= cnt_d;
        end
    end

    assign out_valid     = valid_q;
    assign out_onehot    = onehot_q;
    assign out_opcode    = opcode_q;
    assign out_imm       = imm_q;
    assign out_has_imm   = has_imm_q;
    assign out_illegal   = illegal_q;
    assign illegal_count = cnt_q;

endmodule

// File: tb/tb_instruction_decoder_stream.sv
// Directed vector bench for instruction_decoder_stream; a second instance with a
// 2-bit counter shares all inputs to exercise saturation.
module tb_instruction_decoder_stream;

    logic        clk, rst_n, flush, in_valid, out_ready;
    logic [7:0]  in_data;
    logic        in_ready, out_valid, out_has_imm, out_illegal;
    logic [15:0] out_onehot;
    logic [3:0]  out_opcode;
    logic [7:0]  out_imm, illegal_count;

    logic        in_ready2, out_valid2, out_has_imm2, out_illegal2;
    logic [15:0] out_onehot2;
    logic [3:0]  out_opcode2;
    logic [7:0]  out_imm2;
    logic [1:0]  illegal_count2;

    int n_pass = 0;
    int n_total = 0;

    instruction_decoder_stream dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
        .in_ready(in_ready), .in_data(in_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_onehot(out_onehot), .out_opcode(out_opcode),
        .out_imm(out_imm), .out_has_imm(out_has_imm), .out_illegal(out_illegal),
        .illegal_count(illegal_count)
    );

    instruction_decoder_stream #(.CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
        .in_ready(in_ready2), .in_data(in_data), .out_valid(out_valid2),
        .out_ready(out_ready), .out_onehot(out_onehot2), .out_opcode(out_opcode2),
        .out_imm(out_imm2), .out_has_imm(out_has_imm2), .out_illegal(out_illegal2),
        .illegal_count(illegal_count2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        fl, iv;
        logic [7:0]  d;
        logic        ordy;
        logic        ir;
        logic        ov;
        logic [15:0] oh;
        logic [3:0]  op;
        logic [7:0]  imm;
        logic        hi, il;
        logic [7:0]  cnt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic fl, logic iv, logic [7:0] d, logic ordy, logic ir,
                                logic ov, logic [15:0] oh, logic [3:0] op,
                                logic [7:0] imm, logic hi, logic il, logic [7:0] cnt);
        vec_t v;
        v.fl = fl; v.iv = iv; v.d = d; v.ordy = ordy; v.ir = ir;
        v.ov = ov; v.oh = oh; v.op = op; v.imm = imm; v.hi = hi; v.il = il; v.cnt = cnt;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [63:0] pack_out();
        return {25'd0, out_valid, out_onehot, out_opcode, out_imm, out_has_imm,
                out_illegal, illegal_count};
    endfunction

    function automatic logic [63:0] pack_exp(vec_t v);
        return {25'd0, v.ov, v.oh, v.op, v.imm, v.hi, v.il, v.cnt};
    endfunction

    // One accepted word per cycle with out_ready high; returns after the edge
    task automatic send(input logic [7:0] d);
        flush = 1'b0; in_valid = 1'b1; in_data = d; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    initial begin
        vec_t v;
        logic [7:0] cnt2_exp;

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

        //        fl iv d      or ir | ov oh        op    imm    hi il cnt
        vecs.push_back(mk(0, 1, 8'h3A, 1, 1,  1, 16'h0008, 4'h3, 8'h00, 0, 0, 0));
        vecs.push_back(mk(0, 1, 8'h40, 1, 1,  0, 16'h0008, 4'h3, 8'h00, 0, 0, 0));
        vecs.push_back(mk(0, 1, 8'h5C, 1, 1,  1, 16'h0010, 4'h4, 8'h5C, 1, 0, 0));
        vecs.push_back(mk(0, 1, 8'h90, 1, 1,  1, 16'h0000, 4'h9, 8'h00, 0, 1, 1));
        vecs.push_back(mk(0, 1, 8'hE0, 1, 1,  1, 16'h0000, 4'hE, 8'h00, 0, 1, 2));
        vecs.push_back(mk(0, 1, 8'h95, 1, 1,  1, 16'h0000, 4'h9, 8'h00, 0, 1, 3));
        vecs.push_back(mk(0, 1, 8'hE1, 1, 1,  1, 16'h0000, 4'hE, 8'h00, 0, 1, 4));
        vecs.push_back(mk(0, 1, 8'h9F, 1, 1,  1, 16'h0000, 4'h9, 8'h00, 0, 1, 5));
        // backpressure: three stalled cycles, then the pending 0x10 hands off
        vecs.push_back(mk(0, 1, 8'h10, 0, 0,  1, 16'h0000, 4'h9, 8'h00, 0, 1, 5));
        vecs.push_back(mk(0, 1, 8'h10, 0, 0,  1, 16'h0000, 4'h9, 8'h00, 0, 1, 5));
        vecs.push_back(mk(0, 1, 8'h10, 0, 0,  1, 16'h0000, 4'h9, 8'h00, 0, 1, 5));
        vecs.push_back(mk(0, 1, 8'h10, 1, 1,  1, 16'h0002, 4'h1, 8'h00, 0, 0, 5));
        // top and bottom opcodes
        vecs.push_back(mk(0, 1, 8'hF7, 1, 1,  1, 16'h8000, 4'hF, 8'h00, 0, 0, 5));
        vecs.push_back(mk(0, 1, 8'h00, 1, 1,  1, 16'h0001, 4'h0, 8'h00, 0, 0, 5));
        // flush drops the pending immediate; 0x10 is then an opcode
        vecs.push_back(mk(0, 1, 8'h50, 1, 1,  0, 16'h0001, 4'h0, 8'h00, 0, 0, 5));
        vecs.push_back(mk(1, 1, 8'hAA, 1, 0,  0, 16'h0001, 4'h0, 8'h00, 0, 0, 5));
        vecs.push_back(mk(0, 1, 8'h10, 1, 1,  1, 16'h0002, 4'h1, 8'h00, 0, 0, 5));
        // flush clears a held output, winning over the stall
        vecs.push_back(mk(0, 0, 8'h00, 0, 0,  1, 16'h0002, 4'h1, 8'h00, 0, 0, 5));
        vecs.push_back(mk(1, 0, 8'h00, 0, 0,  0, 16'h0002, 4'h1, 8'h00, 0, 0, 5));
        vecs.push_back(mk(0, 0, 8'h00, 1, 1,  0, 16'h0002, 4'h1, 8'h00, 0, 0, 5));
        // immediate pair under backpressure, then opcode 5 with a zero immediate
        vecs.push_back(mk(0, 1, 8'h41, 0, 1,  0, 16'h0002, 4'h1, 8'h00, 0, 0, 5));
        vecs.push_back(mk(0, 1, 8'hFF, 0, 1,  1, 16'h0010, 4'h4, 8'hFF, 1, 0, 5));
        vecs.push_back(mk(0, 1, 8'h30, 0, 0,  1, 16'h0010, 4'h4, 8'hFF, 1, 0, 5));
        vecs.push_back(mk(0, 1, 8'h30, 1, 1,  1, 16'h0008, 4'h3, 8'h00, 0, 0, 5));
        vecs.push_back(mk(0, 1, 8'h52, 1, 1,  0, 16'h0008, 4'h3, 8'h00, 0, 0, 5));
        vecs.push_back(mk(0, 1, 8'h00, 1, 1,  1, 16'h0020, 4'h5, 8'h00, 1, 0, 5));
        vecs.push_back(mk(0, 0, 8'h00, 1, 1,  0, 16'h0020, 4'h5, 8'h00, 1, 0, 5));

        // reset state
        #2;
        chk("reset in_ready", {63'd0, in_ready}, 64'd0);
        chk("reset outputs", pack_out(), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            v = vecs[i];
            flush = v.fl; in_valid = v.iv; in_data = v.d; out_ready = v.ordy;
            #1;
            chk($sformatf("vec%0d in_ready", i), {63'd0, in_ready}, {63'd0, v.ir});
            @(posedge clk); #1;
            chk($sformatf("vec%0d outputs", i), pack_out(), pack_exp(v));
            cnt2_exp = (v.cnt > 8'd3) ? 8'd3 : v.cnt;
            chk($sformatf("vec%0d sat count", i), {62'd0, illegal_count2}, {56'd0, cnt2_exp});
        end
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;

        // async reset while out_valid=1: outputs clear before the next edge
        send(8'h3A);
        chk("pre-reset valid", {63'd0, out_valid}, 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async reset outputs", pack_out(), 64'd0);
        chk("async reset in_ready", {63'd0, in_ready}, 64'd0);
        @(negedge clk) rst_n = 1'b1;

        // async reset with an immediate pending: next word decodes as an opcode
        send(8'h40);
        chk("pending imm no valid", {63'd0, out_valid}, 64'd0);
        #2 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        @(negedge clk);
        send(8'h20);
        chk("post-reset opcode", pack_out(),
            {25'd0, 1'b1, 16'h0004, 4'h2, 8'h00, 1'b0, 1'b0, 8'h00});

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
